instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter START_ADDR, default 11'd16, PC value after reset.
REQ-002 SHALL have parameter HALT_WORD, default 16'hFFFF, instruction encoding that stops fetch.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  fetch enable; low pauses new SRAM reads.
REQ-006 SHALL have port sram_addr  output  11  registered SRAM word address.
REQ-007 SHALL have port sram_oe_n  output  1  registered active-low SRAM read enable.
REQ-008 SHALL have port sram_rdata  input  16  SRAM read data, valid during the cycle after sram_oe_n was low.
REQ-009 SHALL have port instr  output  16  head-of-queue instruction to decode.
REQ-010 SHALL have port instr_pc  output  11  address instr was fetched from.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-012 SHALL have port instr_ready  input  1  decoder accepts; transfer when valid&&ready at a rising edge.
REQ-013 SHALL have port redirect  input  1  one-cycle request to restart fetch at redirect_addr.
REQ-014 SHALL have port redirect_addr  input  11  new PC.
REQ-015 SHALL have port halted  output  1  high while in HALTED state.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALTED; IDLE->FETCH when run=1; FETCH->IDLE when run=0; FETCH->HALTED on capture of HALT_WORD; HALTED->FETCH on redirect; IDLE->IDLE on redirect (PC loaded only).
REQ-017 SHALL hold a 2-entry FIFO of {word, pc}; instr/instr_pc/instr_valid reflect the head entry.
REQ-018 SHALL issue a read (sram_oe_n=0, sram_addr=pc for exactly one cycle) only in FETCH when fifo_count + inflight - pop < 2, where pop = instr_valid&&instr_ready this cycle.
REQ-019 SHALL increment PC by 1 per issued read, wrapping 11'h7FF -> 11'h000.
REQ-020 SHALL capture sram_rdata at the edge ending the cycle after the read issue and push {data, issued addr} into the FIFO; no overflow is reachable.
REQ-021 SHALL NOT push HALT_WORD; its capture enters HALTED, stops issue, and halted=1 from the next cycle; already-queued entries still drain.
REQ-022 SHALL, on redirect in any state, flush the FIFO, discard any in-flight read data, load PC=redirect_addr, and issue the first read at the following edge if in FETCH/HALTED->FETCH with run=1.
REQ-023 SHALL, on redirect coincident with a transfer, treat the transfer as completed and still flush.
REQ-024 SHALL let redirect win over a coincident HALT_WORD capture (state FETCH, halted=0).
REQ-025 SHALL, when run falls, issue no further reads but still capture the in-flight word; FIFO contents retained and deliverable.
REQ-026 SHALL sustain one transfer per cycle with instr_ready held high.
REQ-027 SHALL drive sram_oe_n=1 in every cycle without an issue.
REQ-028 SHALL hold instr/instr_pc stable while instr_valid=1 and instr_ready=0.

Reset
REQ-029 SHALL on reset set state IDLE, PC=START_ADDR, sram_addr=START_ADDR, sram_oe_n=1, FIFO empty, inflight=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
REQ-030 SHALL let reset override run, redirect and in-flight data; reset mid-fetch discards everything.

Verification
REQ-031 Bench SRAM model words 16..23 = 0..7, run=1, ready=1 -> first read at addr 16 one cycle after run sampled, instr_valid two cycles after, instr 0..7 with instr_pc 16..23 on consecutive cycles.
REQ-032 ready=0 for 5 cycles -> at most 2 reads outstanding/queued, sram_oe_n=1 thereafter, instr held at head; ready=1 resumes in-order, no loss/duplicate.
REQ-033 word 20 = 16'hFFFF -> instrs at 16..19 delivered, halted=1, no read beyond addr 20; redirect to 16 -> halted=0, fetch restarts at 16.
REQ-034 redirect_addr=11'h7FE mid-stream with a read in flight -> stale data dropped, next instrs from 7FE, 7FF, 000.
REQ-035 reset asserted one cycle after a read issue -> all outputs at reset values next cycle, no instr_valid from the dropped read.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a PC through an asynchronous-read SRAM, queues
// fetched words in a 2-entry FIFO for the decoder, and stops on a halt word.
module instr_fetch #(
    parameter logic [10:0] START_ADDR = 11'd16,
    parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [10:0] sram_addr,
    output logic        sram_oe_n,
    input  logic [15:0] sram_rdata,
    output logic [15:0] instr,
    output logic [10:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [10:0] redirect_addr,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t      state, state_nxt;
    logic [10:0] pc;
    logic [15:0] fifo_word [2];
    logic [10:0] fifo_pc   [2];
    logic [1:0]  count;
    logic        inflight, halt_cap, push, pop, issue;
    logic [2:0]  occupancy;

    // The registered read enable doubles as the in-flight flag: the word for
    // the address on sram_addr is present on sram_rdata this same cycle.
    assign inflight  = ~sram_oe_n;
    assign halt_cap  = inflight && (sram_rdata == HALT_WORD);
    assign pop       = instr_valid && instr_ready;
    // Redirect drops any in-flight word; halt words are consumed, not queued.
    assign push      = inflight && !halt_cap && !redirect;
    // pop implies count >= 1, so this never underflows.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == FETCH) && run && !redirect && !halt_cap
                       && (occupancy < 3'd2);

    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? fifo_word[0] : 16'd0;
    assign instr_pc    = instr_valid ? fifo_pc[0]   : 11'd0;
    assign halted      = (state == HALTED);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: redirect beats a coincident halt capture.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = (state == IDLE) ? IDLE : FETCH;
        end else if (halt_cap) begin
            state_nxt = HALTED;
        end else begin
            case (state)
                IDLE:    if (run)  state_nxt = FETCH;
                FETCH:   if (!run) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // PC and SRAM read port; one-cycle read strobe per issued address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= START_ADDR;
            sram_addr <= START_ADDR;
            sram_oe_n <= 1'b1;
        end else begin
            sram_oe_n <= ~issue;
            if (issue) sram_addr <= pc;
            if (redirect)   pc <= redirect_addr;
            else if (issue) pc <= pc + 11'd1;
        end
    end

    // Two-entry FIFO, entry 0 is the head; redirect flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 2'd0;
            fifo_word[0] <= 16'd0;
            fifo_word[1] <= 16'd0;
            fifo_pc[0]   <= 11'd0;
            fifo_pc[1]   <= 11'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        fifo_word[0] <= sram_rdata;
                        fifo_pc[0]   <= sram_addr;
                    end else begin
                        fifo_word[1] <= sram_rdata;
                        fifo_pc[1]   <= sram_addr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    fifo_word[0] <= fifo_word[1];
                    fifo_pc[0]   <= fifo_pc[1];
                    count        <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifo_word[0] <= sram_rdata;
                        fifo_pc[0]   <= sram_addr;
                    end else begin
                        fifo_word[0] <= fifo_word[1];
                        fifo_pc[0]   <= fifo_pc[1];
                        fifo_word[1] <= sram_rdata;
                        fifo_pc[1]   <= sram_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based fetch model.
module tb_instr_fetch;

    localparam logic [10:0] START = 11'd16;
    localparam logic [15:0] HALT  = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset, run, instr_ready, redirect;
    logic [10:0] redirect_addr, sram_addr, instr_pc;
    logic        sram_oe_n, instr_valid, halted;
    logic [15:0] sram_rdata, instr;
    logic [15:0] mem [2048];

    int errors = 0;
    int checks = 0;

    instr_fetch #(.START_ADDR(START), .HALT_WORD(HALT)) dut (
        .clk(clk), .reset(reset), .run(run),
        .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .halted(halted)
    );

    // Asynchronous-read SRAM
    assign sram_rdata = mem[sram_addr];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct packed { logic [15:0] w; logic [10:0] pc; } ent_t;
    ent_t        q[$];
    bit          m_ok = 0, prev_rst = 0;
    int          mode;          // 0 idle, 1 fetching, 2 halted
    logic [10:0] pc_m, cur_rd;  // next address to read; address read this cycle
    bit          cur_oe;        // a read is on the SRAM this cycle

    initial begin
        bit m_pop, m_hc, m_issue;
        logic [15:0] word;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ok = 1; prev_rst = 1; mode = 0; q.delete();
                pc_m = START; cur_rd = START; cur_oe = 0;
            end else if (m_ok) begin
                if (prev_rst) begin
                    chk("rst_addr", sram_addr, START);
                    chk("rst_instr", instr, 0);
                    chk("rst_instr_pc", instr_pc, 0);
                    prev_rst = 0;
                end
                chk("oe_n", sram_oe_n, !cur_oe);
                if (cur_oe) chk("rd_addr", sram_addr, cur_rd);
                chk("valid", instr_valid, q.size() != 0);
                if (q.size() != 0) begin
                    chk("instr", instr, q[0].w);
                    chk("instr_pc", instr_pc, q[0].pc);
                end
                chk("halted", halted, mode == 2);
                // advance model one cycle
                m_pop   = (q.size() != 0) && instr_ready;
                word    = mem[cur_rd];
                m_hc    = cur_oe && (word == HALT);
                m_issue = (mode == 1) && run && !redirect && !m_hc &&
                          (q.size() + int'(cur_oe) - int'(m_pop) < 2);
                if (m_pop) void'(q.pop_front());
                if (redirect) q.delete();
                else if (cur_oe && !m_hc) q.push_back({word, cur_rd});
                if (redirect)                mode = (mode == 0) ? 0 : 1;
                else if (m_hc)               mode = 2;
                else if (mode == 0 && run)   mode = 1;
                else if (mode == 1 && !run)  mode = 0;
                cur_oe = m_issue;
                if (m_issue) begin cur_rd = pc_m; pc_m = pc_m + 11'd1; end
                if (redirect) pc_m = redirect_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] got_pc [3];
        logic [15:0] got_w  [3];
        int  n;
        bit  found;
        reset = 1; run = 0; instr_ready = 0; redirect = 0; redirect_addr = 0;
        for (int i = 0; i < 2048; i++) mem[i] = {5'd0, 11'(i)};
        for (int i = 0; i < 8; i++) mem[16+i] = 16'(i);
        repeat (3) step();

        // Streaming from reset: literal timing and contents
        reset = 0; run = 1; instr_ready = 1;
        @(negedge clk);
        chk("c0_oe_n", sram_oe_n, 1);
        chk("c0_valid", instr_valid, 0);
        chk("c0_halted", halted, 0);
        chk("c0_addr", sram_addr, 16);
        @(negedge clk);
        chk("c1_oe_n", sram_oe_n, 1);
        @(negedge clk);
        chk("c2_oe_n", sram_oe_n, 0);
        chk("c2_addr", sram_addr, 16);
        chk("c2_valid", instr_valid, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_valid", instr_valid, 1);
            chk("stream_instr", instr, k);
            chk("stream_pc", instr_pc, 16 + k);
        end

        // Decoder stall: head held, reads stop
        step(); instr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pc", instr_pc, 24);
            chk("stall_instr", instr, 24);
        end
        chk("stall_oe_n", sram_oe_n, 1);
        step(); instr_ready = 1;
        repeat (6) step();

        // Halt word at 20, then redirect back to 16
        reset = 1; repeat (2) step();
        for (int k = 0; k < 4; k++) mem[16+k] = 16'h0100 + 16'(k);
        mem[20] = HALT;
        reset = 0; run = 1; instr_ready = 1;
        for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1);
        repeat (3) @(negedge clk);
        chk("halt_drained", instr_valid, 0);
        chk("halt_no_read", sram_oe_n, 1);
        step(); redirect = 1; redirect_addr = 11'd16; mem[20] = 16'h0104;
        step(); redirect = 0;
        @(negedge clk);
        chk("redir_unhalt", halted, 0);
        @(negedge clk);
        chk("redir_oe_n", sram_oe_n, 0);
        chk("redir_addr", sram_addr, 16);

        // Redirect to 7FE while a read is in flight
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (!sram_oe_n) found = 1;
        end
        chk("inflight_seen", found, 1);
        redirect = 1; redirect_addr = 11'h7FE;
        step(); redirect = 0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                got_pc[n] = instr_pc; got_w[n] = instr; n++;
            end
        end
        chk("wrap_count", n, 3);
        if (n == 3) begin
            chk("wrap_pc0", got_pc[0], 11'h7FE);
            chk("wrap_pc1", got_pc[1], 11'h7FF);
            chk("wrap_pc2", got_pc[2], 11'h000);
            chk("wrap_w2", got_w[2], 16'h0000);
        end

        // Reset one cycle after a read issue
        step(); reset = 1; repeat (2) step();
        reset = 0; run = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (!sram_oe_n) found = 1;
        end
        chk("pre_rst_read", found, 1);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_sram_addr", sram_addr, START);
        chk("rst_halted", halted, 0);
        chk("rst_instr0", instr, 0);
        step(); reset = 0; run = 0;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 2048; i++)
            mem[i] = ($urandom % 24 == 0) ? HALT : 16'($urandom % 16'hFFFF);
        for (int c = 0; c < 3000; c++) begin
            step();
            reset       = ($urandom % 600 == 0);
            run         = ($urandom % 8 != 0);
            instr_ready = ($urandom % 4 != 0);
            redirect    = ($urandom % 30 == 0);
            redirect_addr = ($urandom % 4 == 0) ? 11'($urandom_range(2040, 2047))
                                                : 11'($urandom);
        end
        step(); reset = 0; redirect = 0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
